// File: rtl/sd_pkg.sv
// Shared types, constants and arithmetic helpers for the 8-PSK sphere decoder.
// Latency: n/a (package). Backpressure: n/a.
// Holds Q1.14 8-PSK tables, the R row-major index map and a complex multiply.
package sd_pkg;

  localparam int SYM_FRAC   = 14;
  localparam int COST_SHIFT = 16;
  localparam int NUM_NODES  = 4680;
  // Helpers work at 64 bits, which covers 2*WIDTH for any WIDTH up to 32.
  localparam int ACC_W      = 64;

  typedef logic [1:0]         lvl_t;
  typedef logic [2:0]         sym_t;
  typedef logic signed [15:0] q14_t;

  typedef enum logic {
    DFS_SEARCH = 1'b0,
    DFS_DONE   = 1'b1
  } dfs_state_t;

  // s_k = cos(k*45deg) + j*sin(k*45deg) in Q1.14
  localparam q14_t PSK_COS [8] = '{16'sd16384, 16'sd11585, 16'sd0, -16'sd11585,
                                   -16'sd16384, -16'sd11585, 16'sd0, 16'sd11585};
  localparam q14_t PSK_SIN [8] = '{16'sd0, 16'sd11585, 16'sd16384, 16'sd11585,
                                   16'sd0, -16'sd11585, -16'sd16384, -16'sd11585};

  typedef struct packed {
    logic [ACC_W-1:0] re;
    logic [ACC_W-1:0] im;
  } cplx_t;

  // Full complex product; fields are two's-complement values.
  function automatic cplx_t cmul(input cplx_t a, input cplx_t b);
    cplx_t p;
    p.re = $signed(a.re) * $signed(b.re) - $signed(a.im) * $signed(b.im);
    p.im = $signed(a.re) * $signed(b.im) + $signed(a.im) * $signed(b.re);
    return p;
  endfunction

  // Flat index of R[row][col] in the row-major upper-triangular list R0..R9.
  function automatic int r_index(input int row, input int col);
    case (row)
      0:       return col;
      1:       return 3 + col;
      2:       return 5 + col;
      default: return 6 + col;
    endcase
  endfunction

endpackage

// File: rtl/dfs.sv
// Exhaustive preorder walk of the 4-level 8-ary tree, one node per clock, with best-leaf tracking.
// Latency: 4680 cycles from reset release to OutputReady. Backpressure: none, free-running.
// Ports: Clk/Reset, current node cost in; node symbols/level, OutputReady and best leaf out.
module dfs
  import sd_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] current_node_cost,
  output logic [2:0]       S_0, S_1, S_2, S_3,
  output logic             OutputReady,
  output logic [2:0]       S_0_best, S_1_best, S_2_best, S_3_best,
  output logic [1:0]       current_node_lvl
);

  dfs_state_t       state_q, state_d;
  lvl_t             lvl_q, lvl_d;
  sym_t             s_q [4];
  sym_t             s_d [4];
  sym_t             best_q [4];
  sym_t             best_d [4];
  logic [WIDTH-1:0] best_cost_q, best_cost_d;

  lvl_t             lvl_dn;
  lvl_t             climb_lvl;
  logic             climb_found;

  always_comb begin
    state_d     = state_q;
    lvl_d       = lvl_q;
    s_d         = s_q;
    best_d      = best_q;
    best_cost_d = best_cost_q;
    lvl_dn      = lvl_q - 2'd1;
    climb_lvl   = 2'd0;
    climb_found = 1'b0;
    unique case (state_q)
      DFS_SEARCH: begin
        if (lvl_q != 2'd0) begin
          lvl_d         = lvl_dn;
          s_d[lvl_dn]   = 3'd0;
        end else if (s_q[0] != 3'd7) begin
          s_d[0] = s_q[0] + 3'd1;
        end else begin
          // Descending scan so the last hit is the lowest level with siblings left.
          for (int l = 3; l >= 1; l--) begin
            if (s_q[l] != 3'd7) begin
              climb_found = 1'b1;
              climb_lvl   = lvl_t'(l);
            end
          end
          if (climb_found) begin
            lvl_d          = climb_lvl;
            s_d[climb_lvl] = s_q[climb_lvl] + 3'd1;
            for (int l = 0; l < 3; l++) begin
              if (l < int'(climb_lvl)) s_d[l] = 3'd0;
            end
          end else begin
            state_d = DFS_DONE;
            lvl_d   = 2'd3;
            s_d     = '{default: 3'd0};
          end
        end
        // Strict compare: on ties the earliest leaf wins.
        if (lvl_q == 2'd0 && current_node_cost < best_cost_q) begin
          best_d      = s_q;
          best_cost_d = current_node_cost;
        end
      end
      DFS_DONE: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= DFS_SEARCH;
      lvl_q       <= 2'd3;
      s_q         <= '{default: 3'd0};
      best_q      <= '{default: 3'd0};
      best_cost_q <= '1;
    end else begin
      state_q     <= state_d;
      lvl_q       <= lvl_d;
      s_q         <= s_d;
      best_q      <= best_d;
      best_cost_q <= best_cost_d;
    end
  end

  assign S_0              = s_q[0];
  assign S_1              = s_q[1];
  assign S_2              = s_q[2];
  assign S_3              = s_q[3];
  assign S_0_best         = best_q[0];
  assign S_1_best         = best_q[1];
  assign S_2_best         = best_q[2];
  assign S_3_best         = best_q[3];
  assign current_node_lvl = lvl_q;
  assign OutputReady      = (state_q == DFS_DONE);

endmodule

// File: rtl/metric_calc.sv
// Partial Euclidean metric of the current tree node, sum over rows i >= lvl of |y_i - (R s)_i|^2.
// Latency: purely combinational. Backpressure: none.
// Ports: y (InData*), R0..R9, node symbols S_0..S_3 and level in; saturated cost out.
module metric_calc
  import sd_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH-1:0] InData0_real, InData1_real, InData2_real, InData3_real,
  input  logic signed [WIDTH-1:0] InData0_imag, InData1_imag, InData2_imag, InData3_imag,
  input  logic [2:0]              S_0, S_1, S_2, S_3,
  input  logic signed [WIDTH-1:0] R0_real, R1_real, R2_real, R3_real, R4_real,
  input  logic signed [WIDTH-1:0] R5_real, R6_real, R7_real, R8_real, R9_real,
  input  logic signed [WIDTH-1:0] R0_imag, R1_imag, R2_imag, R3_imag, R4_imag,
  input  logic signed [WIDTH-1:0] R5_imag, R6_imag, R7_imag, R8_imag, R9_imag,
  input  logic [1:0]              current_node_lvl,
  output logic [WIDTH-1:0]        current_node_cost
);

  localparam int CW = 2 * WIDTH;

  logic signed [WIDTH-1:0] y_re [4];
  logic signed [WIDTH-1:0] y_im [4];
  logic signed [WIDTH-1:0] r_re [10];
  logic signed [WIDTH-1:0] r_im [10];
  sym_t                    s    [4];

  assign y_re = '{InData0_real, InData1_real, InData2_real, InData3_real};
  assign y_im = '{InData0_imag, InData1_imag, InData2_imag, InData3_imag};
  assign r_re = '{R0_real, R1_real, R2_real, R3_real, R4_real,
                  R5_real, R6_real, R7_real, R8_real, R9_real};
  assign r_im = '{R0_imag, R1_imag, R2_imag, R3_imag, R4_imag,
                  R5_imag, R6_imag, R7_imag, R8_imag, R9_imag};
  assign s    = '{S_0, S_1, S_2, S_3};

  cplx_t                a, b, p, acc;
  logic signed [CW-1:0] e_re, e_im;
  logic [CW-1:0]        cost_sum, cost_scaled;

  always_comb begin
    cost_sum    = '0;
    cost_scaled = '0;
    a           = '0;
    b           = '0;
    p           = '0;
    acc         = '0;
    e_re        = '0;
    e_im        = '0;
    for (int i = 0; i < 4; i++) begin
      acc = '0;
      for (int j = 0; j < 4; j++) begin
        if (j >= i) begin
          a.re   = ACC_W'(r_re[r_index(i, j)]);
          a.im   = ACC_W'(r_im[r_index(i, j)]);
          b.re   = ACC_W'(PSK_COS[s[j]]);
          b.im   = ACC_W'(PSK_SIN[s[j]]);
          p      = cmul(a, b);
          acc.re = acc.re + p.re;
          acc.im = acc.im + p.im;
        end
      end
      // Drop the Q1.14 symbol scaling before forming the residual.
      e_re = CW'(ACC_W'(y_re[i]) - ($signed(acc.re) >>> SYM_FRAC));
      e_im = CW'(ACC_W'(y_im[i]) - ($signed(acc.im) >>> SYM_FRAC));
      // Rows below the node level belong to symbols not yet decided.
      if (i >= int'(current_node_lvl)) begin
        cost_sum = cost_sum + CW'(e_re * e_re) + CW'(e_im * e_im);
      end
    end
    cost_scaled       = cost_sum >> COST_SHIFT;
    current_node_cost = (|cost_scaled[CW-1:WIDTH]) ? '1 : cost_scaled[WIDTH-1:0];
  end

endmodule

// File: rtl/sphere_dfs_decoder.sv
// Exhaustive depth-first ML decoder for 4x4 MIMO 8-PSK: dfs controller wired to metric_calc.
// Latency: one node per clock, result 4680 cycles after reset release. Backpressure: none.
// Ports: y and upper-triangular R in; current node, OutputReady and best symbol vector out.
module sphere_dfs_decoder
  import sd_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic signed [WIDTH-1:0] InData0_real, InData1_real, InData2_real, InData3_real,
  input  logic signed [WIDTH-1:0] InData0_imag, InData1_imag, InData2_imag, InData3_imag,
  input  logic signed [WIDTH-1:0] R0_real, R1_real, R2_real, R3_real, R4_real,
  input  logic signed [WIDTH-1:0] R5_real, R6_real, R7_real, R8_real, R9_real,
  input  logic signed [WIDTH-1:0] R0_imag, R1_imag, R2_imag, R3_imag, R4_imag,
  input  logic signed [WIDTH-1:0] R5_imag, R6_imag, R7_imag, R8_imag, R9_imag,
  output logic [2:0]              S_0, S_1, S_2, S_3,
  output logic [1:0]              current_node_lvl,
  output logic [WIDTH-1:0]        current_node_cost,
  output logic                    OutputReady,
  output logic [2:0]              S_0_best, S_1_best, S_2_best, S_3_best
);

  metric_calc #(.WIDTH(WIDTH)) u_metric_calc (
    InData0_real, InData1_real, InData2_real, InData3_real,
    InData0_imag, InData1_imag, InData2_imag, InData3_imag,
    S_0, S_1, S_2, S_3,
    R0_real, R1_real, R2_real, R3_real, R4_real, R5_real, R6_real, R7_real, R8_real, R9_real,
    R0_imag, R1_imag, R2_imag, R3_imag, R4_imag, R5_imag, R6_imag, R7_imag, R8_imag, R9_imag,
    current_node_lvl, current_node_cost
  );

  dfs #(.WIDTH(WIDTH)) u_dfs (
    Clk, Reset, current_node_cost,
    S_0, S_1, S_2, S_3,
    OutputReady,
    S_0_best, S_1_best, S_2_best, S_3_best,
    current_node_lvl
  );

endmodule

// File: tb/tb_sphere_dfs_decoder.sv
// Self-checking bench for sphere_dfs_decoder: directed channels plus random channels
// against a behavioural model (node order from nested loops, cost from the metric formula,
// best = earliest minimum-cost leaf).
module tb_sphere_dfs_decoder;

  localparam int WIDTH     = 32;
  localparam int NUM_NODES = 4680;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  logic signed [WIDTH-1:0] y_re [4];
  logic signed [WIDTH-1:0] y_im [4];
  logic signed [WIDTH-1:0] r_re [10];
  logic signed [WIDTH-1:0] r_im [10];

  logic [2:0]       S_0, S_1, S_2, S_3;
  logic [2:0]       S_0_best, S_1_best, S_2_best, S_3_best;
  logic [1:0]       current_node_lvl;
  logic [WIDTH-1:0] current_node_cost;
  logic             OutputReady;

  int n_checks = 0;
  int n_fail   = 0;

  int          psk_c [8];
  int          psk_s [8];
  logic [13:0] node_list [$];
  longint unsigned model_best_cost;
  logic [11:0]     model_best_vec;

  always #5 Clk = ~Clk;

  sphere_dfs_decoder #(.WIDTH(WIDTH)) dut (
    .Clk(Clk), .Reset(Reset),
    .InData0_real(y_re[0]), .InData1_real(y_re[1]), .InData2_real(y_re[2]), .InData3_real(y_re[3]),
    .InData0_imag(y_im[0]), .InData1_imag(y_im[1]), .InData2_imag(y_im[2]), .InData3_imag(y_im[3]),
    .R0_real(r_re[0]), .R1_real(r_re[1]), .R2_real(r_re[2]), .R3_real(r_re[3]), .R4_real(r_re[4]),
    .R5_real(r_re[5]), .R6_real(r_re[6]), .R7_real(r_re[7]), .R8_real(r_re[8]), .R9_real(r_re[9]),
    .R0_imag(r_im[0]), .R1_imag(r_im[1]), .R2_imag(r_im[2]), .R3_imag(r_im[3]), .R4_imag(r_im[4]),
    .R5_imag(r_im[5]), .R6_imag(r_im[6]), .R7_imag(r_im[7]), .R8_imag(r_im[8]), .R9_imag(r_im[9]),
    .S_0(S_0), .S_1(S_1), .S_2(S_2), .S_3(S_3),
    .current_node_lvl(current_node_lvl),
    .current_node_cost(current_node_cost),
    .OutputReady(OutputReady),
    .S_0_best(S_0_best), .S_1_best(S_1_best), .S_2_best(S_2_best), .S_3_best(S_3_best)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int round_q14(input real x);
    real v;
    v = x * 16384.0;
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  // R stored row-major upper triangle: row i starts at 0, 4, 7, 9.
  function automatic int ridx(input int i, input int j);
    int rbase [4];
    rbase = '{0, 4, 7, 9};
    return rbase[i] + (j - i);
  endfunction

  function automatic longint unsigned model_cost(input int lvl, input int s [4]);
    longint unsigned total;
    longint ar, ai, rr, ri, er, ei;
    total = 0;
    for (int i = lvl; i < 4; i++) begin
      ar = 0;
      ai = 0;
      for (int j = i; j < 4; j++) begin
        rr = r_re[ridx(i, j)];
        ri = r_im[ridx(i, j)];
        ar += rr * psk_c[s[j]] - ri * psk_s[s[j]];
        ai += rr * psk_s[s[j]] + ri * psk_c[s[j]];
      end
      er = longint'(y_re[i]) - (ar >>> 14);
      ei = longint'(y_im[i]) - (ai >>> 14);
      total += longint'(er * er) + longint'(ei * ei);
    end
    total = total >> 16;
    if (total > 64'hFFFF_FFFF) total = 64'hFFFF_FFFF;
    return total;
  endfunction

  function automatic int find_node(input logic [13:0] target);
    for (int k = 0; k < node_list.size(); k++) begin
      if (node_list[k] == target) return k;
    end
    return -1;
  endfunction

  function automatic logic [13:0] dut_pos();
    return {current_node_lvl, S_3, S_2, S_1, S_0};
  endfunction

  function automatic logic [11:0] dut_best();
    return {S_3_best, S_2_best, S_1_best, S_0_best};
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < 4; i++) begin
      y_re[i] = '0;
      y_im[i] = '0;
    end
    for (int i = 0; i < 10; i++) begin
      r_re[i] = '0;
      r_im[i] = '0;
    end
  endtask

  task automatic random_inputs();
    for (int i = 0; i < 4; i++) begin
      y_re[i] = int'($urandom_range(262143, 0)) - 131072;
      y_im[i] = int'($urandom_range(262143, 0)) - 131072;
    end
    for (int i = 0; i < 10; i++) begin
      r_re[i] = int'($urandom_range(262143, 0)) - 131072;
      r_im[i] = int'($urandom_range(262143, 0)) - 131072;
    end
  endtask

  // Ends on a negedge with Reset low and node 0 on the outputs.
  task automatic do_reset();
    Reset = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  // Checks nodes 0..n-1 one per cycle starting at the current negedge.
  task automatic check_nodes(input int n, input int pk0, input logic [63:0] pe0,
                             input int pk1, input logic [63:0] pe1);
    logic [13:0]     nd;
    int              s [4];
    int              l;
    longint unsigned c;
    model_best_cost = 64'hFFFF_FFFF;
    model_best_vec  = '0;
    for (int k = 0; k < n; k++) begin
      nd   = node_list[k];
      l    = int'(nd[13:12]);
      s[3] = int'(nd[11:9]);
      s[2] = int'(nd[8:6]);
      s[1] = int'(nd[5:3]);
      s[0] = int'(nd[2:0]);
      c    = model_cost(l, s);
      chk($sformatf("node%0d_pos", k), dut_pos(), nd);
      chk($sformatf("node%0d_cost", k), current_node_cost, c);
      chk($sformatf("node%0d_ready", k), OutputReady, 0);
      chk($sformatf("node%0d_best", k), dut_best(), model_best_vec);
      if (k == pk0) chk($sformatf("probe_cost_node%0d", k), current_node_cost, pe0);
      if (k == pk1) chk($sformatf("probe_cost_node%0d", k), current_node_cost, pe1);
      if (l == 0 && c < model_best_cost) begin
        model_best_cost = c;
        model_best_vec  = nd[11:0];
      end
      @(negedge Clk);
    end
  endtask

  task automatic check_done(input string tag);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("%s_ready%0d", tag, c), OutputReady, 1);
      chk($sformatf("%s_pos%0d", tag, c), dut_pos(), {2'd3, 12'd0});
      chk($sformatf("%s_best%0d", tag, c), dut_best(), model_best_vec);
      @(negedge Clk);
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      psk_c[k] = round_q14($cos(real'(k) * 3.14159265358979 / 4.0));
      psk_s[k] = round_q14($sin(real'(k) * 3.14159265358979 / 4.0));
    end
    for (int a3 = 0; a3 < 8; a3++) begin
      node_list.push_back({2'd3, 3'(a3), 9'd0});
      for (int a2 = 0; a2 < 8; a2++) begin
        node_list.push_back({2'd2, 3'(a3), 3'(a2), 6'd0});
        for (int a1 = 0; a1 < 8; a1++) begin
          node_list.push_back({2'd1, 3'(a3), 3'(a2), 3'(a1), 3'd0});
          for (int a0 = 0; a0 < 8; a0++) begin
            node_list.push_back({2'd0, 3'(a3), 3'(a2), 3'(a1), 3'(a0)});
          end
        end
      end
    end

    // Single-row metric: only R9 and y3 non-zero.
    clear_inputs();
    r_re[9] = 65536;
    y_re[3] = 65536;
    do_reset();
    chk("rst_pos", dut_pos(), {2'd3, 12'd0});
    chk("rst_ready", OutputReady, 0);
    chk("rst_best", dut_best(), 0);
    check_nodes(NUM_NODES, 0, 0, find_node({2'd3, 3'd4, 9'd0}), 262144);
    check_done("metric");

    // Noiseless identity channel.
    clear_inputs();
    r_re[0] = 65536; r_re[4] = 65536; r_re[7] = 65536; r_re[9] = 65536;
    y_re[0] = -46340; y_im[0] = 46340;
    y_re[1] = 65536;
    y_re[2] = -46340; y_im[2] = -46340;
    y_im[3] = -65536;
    do_reset();
    check_nodes(NUM_NODES, find_node({2'd0, 3'd6, 3'd5, 3'd0, 3'd3}), 0, -1, 0);
    chk("noiseless_best", dut_best(), {3'd6, 3'd5, 3'd0, 3'd3});
    check_done("noiseless");

    // All-zero channel: every cost ties, earliest leaf must win.
    clear_inputs();
    do_reset();
    check_nodes(NUM_NODES, -1, 0, -1, 0);
    chk("tie_best", dut_best(), 0);
    check_done("tie");

    // Random channels.
    for (int r = 0; r < 3; r++) begin
      random_inputs();
      do_reset();
      check_nodes(NUM_NODES, -1, 0, -1, 0);
      check_done($sformatf("rand%0d", r));
    end

    // Reset in the middle of a search restarts from node 0.
    random_inputs();
    do_reset();
    check_nodes(1000, -1, 0, -1, 0);
    Reset = 1'b1;
    @(negedge Clk);
    chk("abort_pos", dut_pos(), {2'd3, 12'd0});
    chk("abort_best", dut_best(), 0);
    chk("abort_ready", OutputReady, 0);
    Reset = 1'b0;
    check_nodes(NUM_NODES, -1, 0, -1, 0);
    check_done("abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
